// File: rtl/pipelined_memory.sv
// Single-port synchronous word memory with byte-enabled writes, out-of-range error
// reporting and a fixed-latency response pipeline that stalls under back-pressure.
module pipelined_memory #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH        = 16,
   parameter int READ_LATENCY = 2,
   parameter int INIT_MODE    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int L     = READ_LATENCY;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Compare width is wider than the address so no high bits are ever dropped.
   localparam int CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH + 1 : 33;

   logic [DATA_WIDTH-1:0] mem_q   [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d   [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q [L];
   logic [DATA_WIDTH-1:0] rdata_d [L];
   logic [L-1:0]          valid_q;
   logic [L-1:0]          valid_d;
   logic [L-1:0]          err_q;
   logic [L-1:0]          err_d;
   logic                  in_range_s;
   logic [IDX_W-1:0]      idx_s;

   function automatic logic [DATA_WIDTH-1:0] init_word(input int i);
      logic [DATA_WIDTH-1:0] w;
      if (INIT_MODE == 1) begin
         w = DATA_WIDTH'(i);
      end else begin
         w = {DATA_WIDTH{1'b0}};
      end
      return w;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] byte_merge(
      input logic [DATA_WIDTH-1:0] old_w,
      input logic [DATA_WIDTH-1:0] new_w,
      input logic [NB-1:0]         be
   );
      logic [DATA_WIDTH-1:0] m;
      for (int k = 0; k < NB; k++) begin
         if (be[k]) begin
            m[8*k +: 8] = new_w[8*k +: 8];
         end else begin
            m[8*k +: 8] = old_w[8*k +: 8];
         end
      end
      return m;
   endfunction

   assign req_ready  = !(resp_valid && !resp_ready);
   assign in_range_s = CMP_W'(req_addr) < CMP_W'(DEPTH);
   assign idx_s      = req_addr[IDX_W-1:0];
   assign resp_valid = valid_q[L-1];
   assign resp_err   = err_q[L-1];
   assign resp_rdata = rdata_q[L-1];

   // Next-state: shift the whole pipeline and apply any write only on advancing edges.
   always_comb begin
      mem_d   = mem_q;
      valid_d = valid_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      if (req_ready) begin
         for (int i = L - 1; i > 0; i--) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = rdata_q[i-1];
         end
         valid_d[0] = req_valid;
         err_d[0]   = req_valid && !in_range_s;
         if (req_valid && in_range_s && !req_write) begin
            rdata_d[0] = mem_q[idx_s];
         end else begin
            rdata_d[0] = {DATA_WIDTH{1'b0}};
         end
         if (req_valid && in_range_s && req_write) begin
            mem_d[idx_s] = byte_merge(mem_q[idx_s], req_wdata, req_be);
         end else begin
            mem_d = mem_q;
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers; reset drops in-flight responses and restores the init pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= init_word(i);
         end
         for (int i = 0; i < L; i++) begin
            rdata_q[i] <= {DATA_WIDTH{1'b0}};
         end
         valid_q <= {L{1'b0}};
         err_q   <= {L{1'b0}};
      end else begin
         mem_q   <= mem_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_pipelined_memory.sv
// Scoreboard bench for pipelined_memory: four instances cover latency 2/1/4 and zero init;
// stimulus pushes expected responses, a negedge monitor pops and compares them.
module tb_pipelined_memory;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
   logic [31:0] req_addr   [4];
   logic [31:0] req_wdata  [4];
   logic [3:0]  req_be     [4];
   logic [31:0] resp_rdata [4];

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   cyc    = 0;
   int   active = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      pipelined_memory #(
         .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16),
         .READ_LATENCY(g == 1 ? 1 : (g == 2 ? 4 : 2)),
         .INIT_MODE(g == 3 ? 0 : 1)
      ) u_dut (
         .clk(clk), .rst(rst),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
         .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_be(req_be[g]),
         .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
         .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g])
      );
   end

   function automatic int lat_of(input int a);
      return (a == 1) ? 1 : ((a == 2) ? 4 : 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s (dut %0d, cycle %0d): got 0x%0h, want 0x%0h", name, active, cyc, act, exp);
      end
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] er, input logic ee,
                        input bit lat, input bit push);
      int   n;
      exp_t e;
      req_valid[active] = 1'b1;
      req_write[active] = w;
      req_addr[active]  = a;
      req_wdata[active] = wd;
      req_be[active]    = be;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[active] && n < 100);
      if (!req_ready[active]) begin
         chk("accept_timeout", 32'(req_ready[active]), 32'd1);
      end else if (push) begin
         e.rdata = er;
         e.err   = ee;
         e.cyc   = lat ? cyc + lat_of(active) : -1;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid[active] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic read_seq(input bit zero_init);
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 32'(i), 32'h0, 4'h0, zero_init ? 32'h0 : 32'(i), 1'b0, 1'b1, 1'b1);
      end
      drain();
   endtask

   // Monitor: every handshake on the active instance must match the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && resp_valid[active] && resp_ready[active]) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rdata", resp_rdata[active], e.rdata);
            chk("err", 32'(resp_err[active]), 32'(e.err));
            if (e.cyc >= 0) chk("latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      int n;
      rst        = 1'b1;
      req_valid  = 4'h0;
      req_write  = 4'h0;
      resp_ready = 4'hF;
      for (int i = 0; i < 4; i++) begin
         req_addr[i]  = 32'h0;
         req_wdata[i] = 32'h0;
         req_be[i]    = 4'h0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[0], 32'h0);
      chk("rst_resp_err", 32'(resp_err[0]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset-value reads, back to back.
      read_seq(1'b0);

      // Byte-enable write then read-back; boundary address 15.
      issue(1'b1, 32'd5, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b1, 1'b1);
      issue(1'b0, 32'd5, 32'h0, 4'h0, 32'h00BB00DD, 1'b0, 1'b1, 1'b1);
      issue(1'b0, 32'd15, 32'h0, 4'h0, 32'd15, 1'b0, 1'b1, 1'b1);
      drain();

      // Out of range: no aliasing of high address bits.
      issue(1'b0, 32'd16, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b1);
      issue(1'b1, 32'h80000003, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1, 1'b1, 1'b1);
      issue(1'b0, 32'd3, 32'h0, 4'h0, 32'd3, 1'b0, 1'b1, 1'b1);
      drain();

      // Back-pressure: hold the first response for three cycles.
      resp_ready[0] = 1'b0;
      fork
         begin
            issue(1'b0, 32'd7, 32'h0, 4'h0, 32'd7, 1'b0, 1'b0, 1'b1);
            issue(1'b0, 32'd8, 32'h0, 4'h0, 32'd8, 1'b0, 1'b0, 1'b1);
            issue(1'b0, 32'd9, 32'h0, 4'h0, 32'd9, 1'b0, 1'b0, 1'b1);
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!resp_valid[0] && n < 50);
            for (int k = 0; k < 3; k++) begin
               if (k > 0) @(negedge clk);
               chk("stall_req_ready", 32'(req_ready[0]), 32'd0);
               chk("stall_resp_valid", 32'(resp_valid[0]), 32'd1);
               chk("stall_rdata", resp_rdata[0], 32'd7);
            end
            @(posedge clk);
            #1;
            resp_ready[0] = 1'b1;
         end
      join
      drain();

      // Reset while a write and a read are in flight; neither response may appear.
      issue(1'b1, 32'd2, 32'h55, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 32'd2, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      issue(1'b0, 32'd2, 32'h0, 4'h0, 32'd2, 1'b0, 1'b1, 1'b1);
      issue(1'b0, 32'd5, 32'h0, 4'h0, 32'd5, 1'b0, 1'b1, 1'b1);
      drain();

      // Latency 1, latency 4, then zero-initialised contents.
      active = 1;
      read_seq(1'b0);
      active = 2;
      read_seq(1'b0);
      active = 3;
      read_seq(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
